// File: rtl/mux_scan_reg_if.sv
// mux_scan_reg_if: channel inputs, select/mode/hold controls and the
// registered output group of the mux_scan_reg block.
interface mux_scan_reg_if #(
  parameter int WIDTH = 32,
  parameter int SELW  = 2
);
  localparam int NCH = 2 ** SELW;

  logic [NCH*WIDTH-1:0] din;
  logic [SELW-1:0]      sel;
  logic                 sel_ld;
  logic                 mode;
  logic                 hold;
  logic [WIDTH-1:0]     dout;
  logic [SELW-1:0]      ch;
  logic                 dout_vld;
  logic                 ch_stb;

  // Driver side (stimulus / upstream logic)
  modport master (
    output din, sel, sel_ld, mode, hold,
    input  dout, ch, dout_vld, ch_stb
  );

  // Mux side
  modport slave (
    input  din, sel, sel_ld, mode, hold,
    output dout, ch, dout_vld, ch_stb
  );
endinterface

// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered NCH:1 multiplexer with direct (commanded) and
// auto-scan channel selection. Auto-scan rotates through the channels,
// dwelling DIV cycles on each.
// Optional feature macro: MUX_SCAN_EN. When undefined, the block is
// direct-only: mode is ignored and no dwell counter exists.
module mux_scan_reg #(
  parameter int WIDTH = 32,
  parameter int SELW  = 2,
  parameter int DIV   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_reg_if.slave   bus
);
  localparam int NCH = 2 ** SELW;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
`ifdef MUX_SCAN_EN
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam int         CNTW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DIV - 1);
`else
  localparam int         unused_div = DIV;
`endif

  logic [1:0]       state_q, state_d;
  logic [1:0]       run_state;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0] dout_q;
  logic [SELW-1:0]  ch_q;
  logic             vld_q;
  logic             stb_q;

  // Unpack the flat input bus into one word per channel
  logic [WIDTH-1:0] chan [NCH];
  for (genvar gi = 0; gi < NCH; gi++) begin : gen_chan
    assign chan[gi] = bus.din[gi*WIDTH +: WIDTH];
  end

`ifdef MUX_SCAN_EN
  assign run_state = bus.mode ? ST_SCAN : ST_DIRECT;
`else
  // Without scan support mode has no effect; everything runs as DIRECT.
  logic unused_mode;
  assign unused_mode = bus.mode;
  assign run_state   = ST_DIRECT;
`endif

  // Leave IDLE on the first unheld edge; afterwards track mode every edge
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (!bus.hold) state_d = run_state;
    end else begin
      state_d = run_state;
    end
  end

`ifdef MUX_SCAN_EN
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Select/dwell update: load beats advance; the counter only runs in SCAN
  // and only while not held, so a DIRECT->SCAN switch starts a full dwell.
  always_comb begin
    sel_d = sel_q;
    cnt_d = cnt_q;
    if (state_q == ST_SCAN) begin
      if (bus.sel_ld) begin
        sel_d = bus.sel;
        cnt_d = '0;
      end else if (!bus.hold) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sel_d = sel_q + SELW'(1);
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
    end else begin
      cnt_d = '0;
      if (bus.sel_ld) sel_d = bus.sel;
    end
  end

  // Dwell counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  // Direct-only select update: load whenever commanded, even while held
  always_comb begin
    sel_d = sel_q;
    if (bus.sel_ld) sel_d = bus.sel;
  end
`endif

  // FSM and select registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Output capture: follow sel_q one edge behind; hold freezes and kills strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      stb_q  <= 1'b0;
    end else if (!bus.hold) begin
      dout_q <= chan[sel_q];
      ch_q   <= sel_q;
      vld_q  <= 1'b1;
      stb_q  <= (sel_q != ch_q);
    end else begin
      stb_q  <= 1'b0;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.ch       = ch_q;
  assign bus.dout_vld = vld_q;
  assign bus.ch_stb   = stb_q;
endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: directed stimulus, a channel-pointer model of the mux
// checked every cycle, plus literal expectations for the key scenarios.
// Scan scenarios are exercised when MUX_SCAN_EN is defined; the direct-only
// scenario otherwise.
module tb_mux_scan_reg;
  localparam int WIDTH = 32;
  localparam int SELW  = 2;
  localparam int NCH   = 4;
  localparam int DIV   = 4;
`ifdef MUX_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_scan_reg_if #(.WIDTH(WIDTH), .SELW(SELW)) bus ();

  mux_scan_reg #(.WIDTH(WIDTH), .SELW(SELW), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  bit run   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Selection is kept as a base channel plus a count of scan cycles elapsed
  // since that base was set; the selected channel is base + elapsed/DIV.
  bit          m_started, m_scan, m_mode_e;
  int          m_ptr, m_el, m_s;
  logic [31:0] m_dout;
  int          m_ch;
  bit          m_vld, m_stb;

  function automatic int cur_sel();
    return (m_ptr + m_el / DIV) % NCH;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 0; m_scan = 0; m_ptr = 0; m_el = 0;
      m_dout = '0; m_ch = 0; m_vld = 0; m_stb = 0;
    end else begin
      m_s      = cur_sel();
      m_mode_e = SCAN_EN && bus.mode;
      if (!bus.hold) begin
        m_stb  = (m_s != m_ch);
        m_dout = bus.din[m_s*WIDTH +: WIDTH];
        m_ch   = m_s;
        m_vld  = 1;
      end else begin
        m_stb = 0;
      end
      if (bus.sel_ld) begin
        m_ptr = int'(bus.sel); m_el = 0;
      end else if (m_scan) begin
        if (!bus.hold) m_el++;
      end else begin
        m_ptr = m_s; m_el = 0;
      end
      if (m_started) m_scan = m_mode_e;
      else if (!bus.hold) begin m_started = 1; m_scan = m_mode_e; end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (run) begin
      check("mdl_dout", bus.dout, m_dout);
      check("mdl_ch", 32'(bus.ch), 32'(m_ch));
      check("mdl_vld", 32'(bus.dout_vld), 32'(m_vld));
      check("mdl_stb", 32'(bus.ch_stb), 32'(m_stb));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int cnt_ch [NCH];
    int n_stb, cnt, lim;
    bit found;

    rst_n = 1'b0;
    bus.sel = '0; bus.sel_ld = 1'b0; bus.mode = 1'b0; bus.hold = 1'b0;
    for (int i = 0; i < NCH; i++) bus.din[i*WIDTH +: WIDTH] = 32'hA000_0000 | 32'(i);
    repeat (2) tick();
    run = 1'b1;
    check("rst_dout", bus.dout, 32'h0);
    check("rst_vld", 32'(bus.dout_vld), 32'h0);
    rst_n = 1'b1;
    tick();
    check("first_dout", bus.dout, 32'hA000_0000);
    check("first_vld", 32'(bus.dout_vld), 32'h1);

    // direct load of channel 2
    bus.sel = 2'd2; bus.sel_ld = 1'b1;
    tick();
    bus.sel_ld = 1'b0;
    check("ld_lat_ch", 32'(bus.ch), 32'h0);
    tick();
    check("ld_dout", bus.dout, 32'hA000_0002);
    check("ld_ch", 32'(bus.ch), 32'h2);
    check("ld_stb", 32'(bus.ch_stb), 32'h1);
    tick();
    check("ld_stb_end", 32'(bus.ch_stb), 32'h0);

    // reload of the same channel: no strobe
    bus.sel_ld = 1'b1;
    tick();
    bus.sel_ld = 1'b0;
    tick();
    check("reload_stb", 32'(bus.ch_stb), 32'h0);
    check("reload_ch", 32'(bus.ch), 32'h2);

    // one-edge data latency
    bus.din[2*WIDTH +: WIDTH] = 32'h1234_5678;
    tick();
    check("data_lat", bus.dout, 32'h1234_5678);

    // hold freezes output; a load under hold takes effect after release
    bus.hold = 1'b1;
    bus.din[2*WIDTH +: WIDTH] = 32'hA000_0002;
    bus.sel = 2'd1; bus.sel_ld = 1'b1;
    tick();
    bus.sel_ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_dout", bus.dout, 32'h1234_5678);
      check("hold_ch", 32'(bus.ch), 32'h2);
      check("hold_stb", 32'(bus.ch_stb), 32'h0);
    end
    bus.hold = 1'b0;
    tick();
    check("rel_dout", bus.dout, 32'hA000_0001);
    check("rel_ch", 32'(bus.ch), 32'h1);
    check("rel_stb", 32'(bus.ch_stb), 32'h1);

`ifndef MUX_SCAN_EN
    // direct-only build: mode is ignored
    bus.sel = 2'd3; bus.sel_ld = 1'b1;
    tick();
    bus.sel_ld = 1'b0;
    tick();
    bus.mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("off_ch", 32'(bus.ch), 32'h3);
      check("off_dout", bus.dout, 32'hA000_0003);
      check("off_stb", 32'(bus.ch_stb), 32'h0);
    end
`else
    // scan wrap: start from channel 0, sample 20 cycles
    bus.sel = 2'd0; bus.sel_ld = 1'b1;
    tick();
    bus.sel_ld = 1'b0; bus.mode = 1'b1;
    for (int i = 0; i < NCH; i++) cnt_ch[i] = 0;
    n_stb = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt_ch[bus.ch]++;
      if (bus.ch_stb) n_stb++;
    end
    check("scan_ch1_len", 32'(cnt_ch[1]), 32'd4);
    check("scan_ch2_len", 32'(cnt_ch[2]), 32'd4);
    check("scan_ch3_len", 32'(cnt_ch[3]), 32'd4);
    check("scan_stbs", 32'(n_stb), 32'd5);
    check("scan_wrap_ch", 32'(bus.ch), 32'h0);

    // hold in the second cycle of ch=1
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.ch == 2'd1 && bus.ch_stb) found = 1;
    end
    check("wait_ch1", 32'(found), 32'h1);
    tick();
    bus.hold = 1'b1;
    repeat (6) tick();
    bus.hold = 1'b0;
    cnt = 0; lim = 0;
    do begin tick(); lim++; if (bus.ch == 2'd1) cnt++; end
    while (bus.ch == 2'd1 && lim < 12);
    check("hold_resume_len", 32'(cnt), 32'd2);
    check("hold_next_ch", 32'(bus.ch), 32'h2);

    // load at the edge where ch=2 would advance
    tick(); tick();
    bus.sel = 2'd0; bus.sel_ld = 1'b1;
    tick();
    bus.sel_ld = 1'b0;
    cnt = 0; lim = 0;
    do begin tick(); lim++; end while (bus.ch == 2'd2 && lim < 12);
    check("lva_next_ch", 32'(bus.ch), 32'h0);
    cnt = 1; lim = 0;
    do begin tick(); lim++; if (bus.ch == 2'd0) cnt++; end
    while (bus.ch == 2'd0 && lim < 12);
    check("lva_dwell", 32'(cnt), 32'd4);
`endif

    // asynchronous reset between edges while running
    repeat (3) tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_dout", bus.dout, 32'h0);
    check("arst_ch", 32'(bus.ch), 32'h0);
    check("arst_vld", 32'(bus.dout_vld), 32'h0);
    check("arst_stb", 32'(bus.ch_stb), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_dout", bus.dout, 32'hA000_0000);
    check("post_vld", 32'(bus.dout_vld), 32'h1);
    repeat (6) tick();
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
